// File: rtl/hit_judge.sv
// Four-column hit judge: turns each accepted press edge into a one-cycle row
// judgment and tracks judged lights in the bottom rows so unjudged exits are reported.
module hit_judge #(
    parameter int LOCKOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key,
    input  logic [63:0] lights,
    input  logic        tick,
    output logic [63:0] user_entries,
    output logic [3:0]  light_lost,
    output logic [3:0]  empty_press
);
    localparam int NCOL   = 4;
    localparam int ROWS   = 16;
    localparam int LOCK_W = 3;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT);

    generate
        for (genvar gi = 0; gi < NCOL; gi++) begin : g_col
            logic [ROWS-1:0]   col_lights;
            logic              key_q;
            logic [LOCK_W-1:0] lock_cnt_q;
            logic [LOCK_W-1:0] lock_cnt_d;
            logic              press_edge;
            logic [ROWS-1:0]   miss_row;
            logic [ROWS-1:0]   judge_d;
            logic              empty_d;
            logic              m13_q, m14_q, m15_q;
            logic              m13_d, m14_d, m15_d;
            logic              lost_d;
            logic [ROWS-1:0]   entries_q;
            logic              empty_q;
            logic              lost_q;

            assign col_lights = lights[ROWS*gi +: ROWS];
            assign press_edge = key[gi] & ~key_q & (lock_cnt_q == '0);

            // Highest lit row among the early rows; later iterations override earlier ones.
            always_comb begin
                miss_row = '0;
                for (int r = 0; r <= 12; r++) begin
                    if (col_lights[r]) begin
                        miss_row    = '0;
                        miss_row[r] = 1'b1;
                    end
                end
            end

            always_comb begin
                judge_d = '0;
                empty_d = 1'b0;
                if (press_edge) begin
                    if (col_lights[14]) begin
                        judge_d[14] = 1'b1;
                    end else if (col_lights[15]) begin
                        judge_d[15] = 1'b1;
                    end else if (col_lights[13]) begin
                        judge_d[13] = 1'b1;
                    end else if (|col_lights[12:0]) begin
                        judge_d = miss_row;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end

            always_comb begin
                lock_cnt_d = lock_cnt_q;
                if (press_edge) begin
                    lock_cnt_d = LOCK_LOAD;
                end else if (lock_cnt_q != '0) begin
                    lock_cnt_d = lock_cnt_q - LOCK_W'(1);
                end
            end

            // Marks follow the board: on tick a fresh judgment lands one row further down,
            // and a row-15 judgment leaves the board together with its light.
            always_comb begin
                if (tick) begin
                    m13_d  = 1'b0;
                    m14_d  = m13_q | judge_d[13];
                    m15_d  = m14_q | judge_d[14];
                    lost_d = col_lights[15] & ~m15_q & ~judge_d[15];
                end else begin
                    m13_d  = m13_q | judge_d[13];
                    m14_d  = m14_q | judge_d[14];
                    m15_d  = m15_q | judge_d[15];
                    lost_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    key_q      <= 1'b1;
                    lock_cnt_q <= '0;
                    m13_q      <= 1'b0;
                    m14_q      <= 1'b0;
                    m15_q      <= 1'b0;
                    entries_q  <= '0;
                    empty_q    <= 1'b0;
                    lost_q     <= 1'b0;
                end else begin
                    key_q      <= key[gi];
                    lock_cnt_q <= lock_cnt_d;
                    m13_q      <= m13_d;
                    m14_q      <= m14_d;
                    m15_q      <= m15_d;
                    entries_q  <= judge_d;
                    empty_q    <= empty_d;
                    lost_q     <= lost_d;
                end
            end

            assign user_entries[ROWS*gi +: ROWS] = entries_q;
            assign empty_press[gi]               = empty_q;
            assign light_lost[gi]                = lost_q;
        end
    endgenerate
endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed cycle table followed by random traffic against a board-level model.
module tb_hit_judge;
    localparam int LOCKOUT = 4;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic [3:0]  key    = '0;
    logic [63:0] lights = '0;
    logic        tick   = 1'b0;
    logic [63:0] user_entries;
    logic [3:0]  light_lost;
    logic [3:0]  empty_press;

    hit_judge #(.LOCKOUT(LOCKOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .key          (key),
        .lights       (lights),
        .tick         (tick),
        .user_entries (user_entries),
        .light_lost   (light_lost),
        .empty_press  (empty_press)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  key;
        logic [63:0] lights;
        logic        tick;
        logic [63:0] exp_ue;
        logic [3:0]  exp_lost;
        logic [3:0]  exp_empty;
    } vec_t;
    vec_t vecs[$];

    typedef struct {
        int col;
        int row;
    } mark_t;

    // Reference model state: judged lights still on the board, last accepted press per column.
    mark_t       m_marks[$];
    logic [3:0]  m_prev_key = 4'b1111;
    int          m_last_acc[4] = '{-1000, -1000, -1000, -1000};
    int          m_cyc = 0;
    logic [63:0] m_ue;
    logic [3:0]  m_lost;
    logic [3:0]  m_empty;

    function automatic logic [63:0] lit(input int c, input int r);
        logic [63:0] v;
        v = '0;
        v[16*c+r] = 1'b1;
        return v;
    endfunction

    task automatic add(input string n, input logic r, input logic [3:0] k, input logic [63:0] l,
                       input logic t, input logic [63:0] eu, input logic [3:0] el, input logic [3:0] ee);
        vecs.push_back('{n, r, k, l, t, eu, el, ee});
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] k, input logic [63:0] l, input logic t);
        logic [15:0] col;
        bit          acc;
        bit          seen15;
        int          jr;
        mark_t       kept[$];
        m_ue    = '0;
        m_lost  = '0;
        m_empty = '0;
        m_cyc++;
        if (r) begin
            m_marks.delete();
            m_prev_key = 4'b1111;
            for (int c = 0; c < 4; c++) m_last_acc[c] = -1000;
            return;
        end
        for (int c = 0; c < 4; c++) begin
            col = l[16*c +: 16];
            acc = k[c] && !m_prev_key[c] && (m_cyc - m_last_acc[c] > LOCKOUT);
            jr  = -1;
            if (acc) begin
                m_last_acc[c] = m_cyc;
                if (col[14]) jr = 14;
                else if (col[15]) jr = 15;
                else if (col[13]) jr = 13;
                else begin
                    for (int rr = 12; rr >= 0; rr--) begin
                        if (jr < 0 && col[rr]) jr = rr;
                    end
                end
                if (jr < 0) m_empty[c] = 1'b1;
                else m_ue[16*c+jr] = 1'b1;
            end
            seen15 = 0;
            foreach (m_marks[i]) begin
                if (m_marks[i].col == c && m_marks[i].row == 15) seen15 = 1;
            end
            if (t && col[15] && !seen15 && jr != 15) m_lost[c] = 1'b1;
            if (jr >= 13) m_marks.push_back('{c, jr});
        end
        m_prev_key = k;
        if (t) begin
            foreach (m_marks[i]) begin
                if (m_marks[i].row < 15) kept.push_back('{m_marks[i].col, m_marks[i].row + 1});
            end
            m_marks = kept;
        end
    endtask

    task automatic do_cycle(input logic r, input logic [3:0] k, input logic [63:0] l, input logic t);
        @(negedge clk);
        reset  = r;
        key    = k;
        lights = l;
        tick   = t;
        model_step(r, k, l, t);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_lights();
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            case ($urandom_range(0, 4))
                1: v[16*c + $urandom_range(0, 15)] = 1'b1;
                2: v[16*c+13 +: 3] = 3'($urandom);
                3: v[16*c +: 16] = 16'($urandom & $urandom);
                4: v[16*c+15] = 1'b1;
                default: ;
            endcase
        end
        return v;
    endfunction

    initial begin
        logic [63:0] four;
        logic        r_rst;
        logic [3:0]  r_key;
        logic [63:0] r_lights;
        logic        r_tick;

        four = lit(0, 14) | lit(1, 15) | lit(2, 13) | lit(3, 5);

        add("reset", 1, 4'b0000, '0, 0, '0, 4'b0000, 4'b0000);
        // Row-14 hit on column 0, then a long hold.
        add("idle24", 0, 4'b0000, lit(0, 14), 0, '0, 4'b0000, 4'b0000);
        add("press24", 0, 4'b0001, lit(0, 14), 0, 64'h4000, 4'b0000, 4'b0000);
        for (int i = 0; i < 10; i++) add("hold24", 0, 4'b0001, lit(0, 14), 0, '0, 4'b0000, 4'b0000);
        add("rel24", 0, 4'b0000, lit(0, 14), 0, '0, 4'b0000, 4'b0000);
        // Row-15 hit on column 2 then tick: no lost light.
        add("reset", 1, 4'b0000, '0, 0, '0, 4'b0000, 4'b0000);
        add("idle25", 0, 4'b0000, lit(2, 15), 0, '0, 4'b0000, 4'b0000);
        add("press25", 0, 4'b0100, lit(2, 15), 0, 64'h0000_8000_0000_0000, 4'b0000, 4'b0000);
        add("tick25", 0, 4'b0000, lit(2, 15), 1, '0, 4'b0000, 4'b0000);
        add("after25", 0, 4'b0000, '0, 0, '0, 4'b0000, 4'b0000);
        // Row-15 hit in the tick cycle itself.
        add("reset", 1, 4'b0000, '0, 0, '0, 4'b0000, 4'b0000);
        add("idle19", 0, 4'b0000, lit(1, 15), 0, '0, 4'b0000, 4'b0000);
        add("ptick19", 0, 4'b0010, lit(1, 15), 1, lit(1, 15), 4'b0000, 4'b0000);
        add("after19", 0, 4'b0000, '0, 0, '0, 4'b0000, 4'b0000);
        // Row-14 hit with tick while row 15 is unjudged: both pulses, hit mark shifted to 15.
        add("reset", 1, 4'b0000, '0, 0, '0, 4'b0000, 4'b0000);
        add("idle20", 0, 4'b0000, lit(1, 14) | lit(1, 15), 0, '0, 4'b0000, 4'b0000);
        add("both20", 0, 4'b0010, lit(1, 14) | lit(1, 15), 1, lit(1, 14), 4'b0010, 4'b0000);
        add("after20", 0, 4'b0000, lit(1, 15), 0, '0, 4'b0000, 4'b0000);
        add("tick20", 0, 4'b0000, lit(1, 15), 1, '0, 4'b0000, 4'b0000);
        // Miss on column 3 picks the highest lit row, then an empty press.
        add("reset", 1, 4'b0000, '0, 0, '0, 4'b0000, 4'b0000);
        add("idle26", 0, 4'b0000, lit(3, 3) | lit(3, 7), 0, '0, 4'b0000, 4'b0000);
        add("press26", 0, 4'b1000, lit(3, 3) | lit(3, 7), 0, 64'h0080_0000_0000_0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) add("wait26", 0, 4'b0000, '0, 0, '0, 4'b0000, 4'b0000);
        add("empty26", 0, 4'b1000, '0, 0, '0, 4'b0000, 4'b1000);
        add("after26", 0, 4'b0000, '0, 0, '0, 4'b0000, 4'b0000);
        // Unjudged row-15 exit on column 1, then a judged light surviving two ticks.
        add("reset", 1, 4'b0000, '0, 0, '0, 4'b0000, 4'b0000);
        add("idle27", 0, 4'b0000, lit(1, 15), 0, '0, 4'b0000, 4'b0000);
        add("tick27", 0, 4'b0000, lit(1, 15), 1, '0, 4'b0010, 4'b0000);
        add("after27", 0, 4'b0000, lit(1, 14), 0, '0, 4'b0000, 4'b0000);
        add("press27", 0, 4'b0010, lit(1, 14), 0, lit(1, 14), 4'b0000, 4'b0000);
        add("tickA27", 0, 4'b0000, lit(1, 14), 1, '0, 4'b0000, 4'b0000);
        add("tickB27", 0, 4'b0000, lit(1, 15), 1, '0, 4'b0000, 4'b0000);
        add("end27", 0, 4'b0000, '0, 0, '0, 4'b0000, 4'b0000);
        // Lockout window.
        add("reset", 1, 4'b0000, '0, 0, '0, 4'b0000, 4'b0000);
        add("idle28", 0, 4'b0000, lit(0, 14), 0, '0, 4'b0000, 4'b0000);
        add("press28", 0, 4'b0001, lit(0, 14), 0, 64'h4000, 4'b0000, 4'b0000);
        add("rel28", 0, 4'b0000, lit(0, 14), 0, '0, 4'b0000, 4'b0000);
        add("locked28", 0, 4'b0001, lit(0, 14), 0, '0, 4'b0000, 4'b0000);
        add("rel28b", 0, 4'b0000, lit(0, 14), 0, '0, 4'b0000, 4'b0000);
        add("rel28c", 0, 4'b0000, lit(0, 14), 0, '0, 4'b0000, 4'b0000);
        add("repress28", 0, 4'b0001, lit(0, 14), 0, 64'h4000, 4'b0000, 4'b0000);
        add("rel28d", 0, 4'b0000, lit(0, 14), 0, '0, 4'b0000, 4'b0000);
        // Press during reset, key held through reset release, then four columns at once.
        add("rstpress23", 1, 4'b0001, lit(0, 14), 0, '0, 4'b0000, 4'b0000);
        add("hold29", 0, 4'b0001, lit(0, 14), 0, '0, 4'b0000, 4'b0000);
        add("hold29b", 0, 4'b0001, lit(0, 14), 0, '0, 4'b0000, 4'b0000);
        add("rel29", 0, 4'b0000, four, 0, '0, 4'b0000, 4'b0000);
        add("all29", 0, 4'b1111, four, 0, four, 4'b0000, 4'b0000);
        add("after29", 0, 4'b0000, '0, 0, '0, 4'b0000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            do_cycle(vecs[i].rst, vecs[i].key, vecs[i].lights, vecs[i].tick);
            check({vecs[i].name, ".ue"}, user_entries, vecs[i].exp_ue);
            check({vecs[i].name, ".lost"}, 64'(light_lost), 64'(vecs[i].exp_lost));
            check({vecs[i].name, ".empty"}, 64'(empty_press), 64'(vecs[i].exp_empty));
            $display("vec %0d %s: ue=%h lost=%b empty=%b", i, vecs[i].name, user_entries, light_lost, empty_press);
        end

        do_cycle(1'b1, 4'b0000, '0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            r_rst    = ($urandom_range(0, 63) == 0);
            r_key    = 4'($urandom & $urandom);
            r_lights = rand_lights();
            r_tick   = ($urandom_range(0, 2) == 0);
            do_cycle(r_rst, r_key, r_lights, r_tick);
            check("rand.ue", user_entries, m_ue);
            check("rand.lost", 64'(light_lost), 64'(m_lost));
            check("rand.empty", 64'(empty_press), 64'(m_empty));
            $display("rand %0d: rst=%b key=%b tick=%b ue=%h lost=%b empty=%b",
                     n, r_rst, r_key, r_tick, user_entries, light_lost, empty_press);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
